// File: rtl/multi_phase_traffic_controller.sv
// Multi-phase intersection controller.
// Cycles NUM_PHASES approach groups through GREEN -> YELLOW -> ALL_RED, with
// per-phase green durations, pedestrian walk service on green entry, an
// all-red hold for reconfiguration and an all-phase flashing-yellow
// maintenance mode. Every timer counts external time-base ticks, and every
// lamp output is registered.
module multi_phase_traffic_controller #(
    parameter  int NUM_PHASES = 2,
    parameter  int TIME_W     = 8,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_en,
    input  logic                         config_mode,
    input  logic                         maint_mode,
    input  logic [NUM_PHASES*TIME_W-1:0] green_time,
    input  logic [TIME_W-1:0]            yellow_time,
    input  logic [TIME_W-1:0]            allred_time,
    input  logic [NUM_PHASES-1:0]        ped_req,
    output logic [NUM_PHASES-1:0]        red,
    output logic [NUM_PHASES-1:0]        yellow,
    output logic [NUM_PHASES-1:0]        green,
    output logic [NUM_PHASES-1:0]        walk,
    output logic [PH_W-1:0]              active_phase
);

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_HOLD,
        ST_FLASH
    } state_t;

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

    state_t                  state;
    logic [TIME_W-1:0]       timer;
    logic [NUM_PHASES-1:0]   ped_pending;
    logic                    flash;

    logic [PH_W-1:0]         next_phase;
    logic [NUM_PHASES-1:0]   next_mask;
    logic [NUM_PHASES-1:0]   active_mask;
    logic [TIME_W-1:0]       next_green;

    // A duration D lasts D ticks: load D-1 and exit on the tick seen at zero.
    // A zero duration is stretched to a single tick.
    function automatic logic [TIME_W-1:0] dur_to_count(input logic [TIME_W-1:0] dur);
        return (dur == '0) ? '0 : dur - TIME_W'(1);
    endfunction

    // Decode the phase that would be served next, its lamp mask and its green duration
    always_comb begin
        next_phase  = (active_phase == LAST_PHASE) ? '0 : active_phase + PH_W'(1);
        next_mask   = '0;
        active_mask = '0;
        next_green  = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (next_phase == PH_W'(i)) begin
                next_mask[i] = 1'b1;
                next_green   = green_time[i*TIME_W +: TIME_W];
            end
            if (active_phase == PH_W'(i)) begin
                active_mask[i] = 1'b1;
            end
        end
    end

    // Sequencer: mode overrides first, then tick-driven interval timing, lamps registered alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ALL_RED;
            timer        <= '0;
            active_phase <= LAST_PHASE;
            red          <= '1;
            yellow       <= '0;
            green        <= '0;
            walk         <= '0;
            ped_pending  <= '0;
            flash        <= 1'b0;
        end else begin
            ped_pending <= ped_pending | ped_req;

            if (maint_mode) begin
                red   <= '0;
                green <= '0;
                walk  <= '0;
                if (state != ST_FLASH) begin
                    state  <= ST_FLASH;
                    flash  <= 1'b1;
                    yellow <= '1;
                end else if (tick_en) begin
                    flash  <= ~flash;
                    yellow <= {NUM_PHASES{~flash}};
                end
            end else if (state == ST_FLASH) begin
                flash        <= 1'b0;
                active_phase <= LAST_PHASE;
                red          <= '1;
                yellow       <= '0;
                green        <= '0;
                walk         <= '0;
                if (config_mode) begin
                    state <= ST_HOLD;
                end else begin
                    state <= ST_ALL_RED;
                    timer <= dur_to_count(allred_time);
                end
            end else if (config_mode) begin
                state  <= ST_HOLD;
                red    <= '1;
                yellow <= '0;
                green  <= '0;
                walk   <= '0;
            end else if (state == ST_HOLD) begin
                state <= ST_ALL_RED;
                timer <= dur_to_count(allred_time);
            end else if (tick_en) begin
                if (timer != '0) begin
                    timer <= timer - TIME_W'(1);
                end else begin
                    case (state)
                        ST_ALL_RED: begin
                            state        <= ST_GREEN;
                            active_phase <= next_phase;
                            timer        <= dur_to_count(next_green);
                            green        <= next_mask;
                            red          <= ~next_mask;
                            yellow       <= '0;
                            walk         <= ped_pending & next_mask;
                            ped_pending  <= (ped_pending & ~next_mask) | ped_req;
                        end
                        ST_GREEN: begin
                            state  <= ST_YELLOW;
                            timer  <= dur_to_count(yellow_time);
                            yellow <= active_mask;
                            red    <= ~active_mask;
                            green  <= '0;
                            walk   <= '0;
                        end
                        ST_YELLOW: begin
                            state  <= ST_ALL_RED;
                            timer  <= dur_to_count(allred_time);
                            red    <= '1;
                            yellow <= '0;
                            green  <= '0;
                            walk   <= '0;
                        end
                        default: begin
                            state  <= ST_ALL_RED;
                            timer  <= dur_to_count(allred_time);
                            red    <= '1;
                            yellow <= '0;
                            green  <= '0;
                            walk   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed testbench for multi_phase_traffic_controller with three phases.
// A table of tick-period records walks the normal sequence; hand-written
// sequences cover duration boundaries, hold, maintenance flash and reset.
module tb_multi_phase_traffic_controller;

    localparam int NP = 3;
    localparam int TW = 8;

    logic            clk;
    logic            rst_n;
    logic            tick_en;
    logic            config_mode;
    logic            maint_mode;
    logic [NP*TW-1:0] green_time;
    logic [TW-1:0]   yellow_time;
    logic [TW-1:0]   allred_time;
    logic [NP-1:0]   ped_req;
    logic [NP-1:0]   red;
    logic [NP-1:0]   yellow;
    logic [NP-1:0]   green;
    logic [NP-1:0]   walk;
    logic [1:0]      active_phase;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         n;
        logic [2:0] ped;
        logic [2:0] e_red;
        logic [2:0] e_yel;
        logic [2:0] e_grn;
        logic [2:0] e_walk;
        logic [1:0] e_ph;
    } vec_t;

    vec_t vecs[19];

    multi_phase_traffic_controller #(
        .NUM_PHASES(NP),
        .TIME_W(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_en(tick_en),
        .config_mode(config_mode),
        .maint_mode(maint_mode),
        .green_time(green_time),
        .yellow_time(yellow_time),
        .allred_time(allred_time),
        .ped_req(ped_req),
        .red(red),
        .yellow(yellow),
        .green(green),
        .walk(walk),
        .active_phase(active_phase)
    );

    // 10-unit free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string name, input string field,
                                input logic [2:0] got, input logic [2:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %b want %b", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] e_red,
                               input logic [2:0] e_yel, input logic [2:0] e_grn,
                               input logic [2:0] e_walk, input logic [1:0] e_ph);
        compareField(name, "red", red, e_red);
        compareField(name, "yellow", yellow, e_yel);
        compareField(name, "green", green, e_grn);
        compareField(name, "walk", walk, e_walk);
        compareField(name, "phase", {1'b0, active_phase}, {1'b0, e_ph});
    endtask

    // One plain clock cycle with tick_en low
    task automatic oneCycle();
        @(posedge clk);
        #1;
    endtask

    // n tick periods of four cycles each, tick on the first; ped pulsed on the first tick only
    task automatic applyStimulus(input int n, input logic [2:0] ped);
        for (int k = 0; k < n; k++) begin
            ped_req = (k == 0) ? ped : 3'b000;
            tick_en = 1'b1;
            @(posedge clk);
            #1;
            tick_en = 1'b0;
            ped_req = 3'b000;
            repeat (3) oneCycle();
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        oneCycle();
        oneCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // n, ped, red, yellow, green, walk, phase
        vecs[0]  = '{1, 3'b000, 3'b110, 3'b000, 3'b001, 3'b000, 2'd0};
        vecs[1]  = '{2, 3'b010, 3'b110, 3'b000, 3'b001, 3'b000, 2'd0};
        vecs[2]  = '{2, 3'b000, 3'b110, 3'b000, 3'b001, 3'b000, 2'd0};
        vecs[3]  = '{1, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 2'd0};
        vecs[4]  = '{1, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 2'd0};
        vecs[5]  = '{1, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0};
        vecs[6]  = '{1, 3'b010, 3'b101, 3'b000, 3'b010, 3'b010, 2'd1};
        vecs[7]  = '{5, 3'b000, 3'b101, 3'b000, 3'b010, 3'b010, 2'd1};
        vecs[8]  = '{1, 3'b000, 3'b101, 3'b010, 3'b000, 3'b000, 2'd1};
        vecs[9]  = '{2, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 2'd1};
        vecs[10] = '{1, 3'b000, 3'b011, 3'b000, 3'b100, 3'b000, 2'd2};
        vecs[11] = '{6, 3'b000, 3'b011, 3'b000, 3'b100, 3'b000, 2'd2};
        vecs[12] = '{1, 3'b000, 3'b011, 3'b100, 3'b000, 3'b000, 2'd2};
        vecs[13] = '{2, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 2'd2};
        vecs[14] = '{1, 3'b000, 3'b110, 3'b000, 3'b001, 3'b000, 2'd0};
        vecs[15] = '{5, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 2'd0};
        vecs[16] = '{2, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0};
        vecs[17] = '{1, 3'b000, 3'b101, 3'b000, 3'b010, 3'b010, 2'd1};
        vecs[18] = '{6, 3'b000, 3'b101, 3'b010, 3'b000, 3'b000, 2'd1};

        rst_n       = 1'b0;
        tick_en     = 1'b0;
        config_mode = 1'b0;
        maint_mode  = 1'b0;
        ped_req     = 3'b000;
        green_time  = {8'd7, 8'd6, 8'd5};
        yellow_time = 8'd2;
        allred_time = 8'd1;
        oneCycle();
        oneCycle();
        checkOutput("reset", 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        rst_n = 1'b1;

        // Normal sequence with walk service and wrap 2 -> 0
        for (int v = 0; v < 19; v++) begin
            applyStimulus(vecs[v].n, vecs[v].ped);
            checkOutput($sformatf("vec%0d", v), vecs[v].e_red, vecs[v].e_yel,
                        vecs[v].e_grn, vecs[v].e_walk, vecs[v].e_ph);
        end

        // Zero green duration, yellow and all-red changed mid-interval
        $display("[TB] duration boundary sequence");
        doReset();
        green_time = {8'd7, 8'd6, 8'd0};
        applyStimulus(1, 3'b000);
        checkOutput("dur_g0", 3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        yellow_time = 8'd4;
        applyStimulus(1, 3'b000);
        checkOutput("dur_g0_one_tick", 3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        allred_time = 8'd3;
        applyStimulus(3, 3'b000);
        checkOutput("dur_y_still", 3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        applyStimulus(1, 3'b000);
        checkOutput("dur_y_end", 3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        applyStimulus(2, 3'b000);
        checkOutput("dur_ar_still", 3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        applyStimulus(1, 3'b000);
        checkOutput("dur_ar_end", 3'b101, 3'b000, 3'b010, 3'b000, 2'd1);

        // Config hold mid phase-1 green
        $display("[TB] config hold sequence");
        allred_time = 8'd1;
        yellow_time = 8'd2;
        applyStimulus(2, 3'b000);
        config_mode = 1'b1;
        oneCycle();
        checkOutput("hold_entry", 3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        applyStimulus(3, 3'b000);
        checkOutput("hold_stay", 3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        config_mode = 1'b0;
        oneCycle();
        checkOutput("hold_release", 3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        applyStimulus(1, 3'b000);
        checkOutput("hold_next_g2", 3'b011, 3'b000, 3'b100, 3'b000, 2'd2);

        // Maintenance flash over config
        $display("[TB] maintenance flash sequence");
        config_mode = 1'b1;
        maint_mode  = 1'b1;
        oneCycle();
        checkOutput("flash_entry", 3'b000, 3'b111, 3'b000, 3'b000, 2'd2);
        applyStimulus(1, 3'b000);
        checkOutput("flash_tick1", 3'b000, 3'b000, 3'b000, 3'b000, 2'd2);
        applyStimulus(1, 3'b000);
        checkOutput("flash_tick2", 3'b000, 3'b111, 3'b000, 3'b000, 2'd2);
        maint_mode = 1'b0;
        oneCycle();
        checkOutput("flash_to_hold", 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        config_mode = 1'b0;
        oneCycle();
        checkOutput("flash_hold_rel", 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        applyStimulus(1, 3'b000);
        checkOutput("flash_restart_g0", 3'b110, 3'b000, 3'b001, 3'b000, 2'd0);

        // Flash from phase 0 restarts service at phase 0, not phase 1
        maint_mode = 1'b1;
        oneCycle();
        checkOutput("flash2_entry", 3'b000, 3'b111, 3'b000, 3'b000, 2'd0);
        maint_mode = 1'b0;
        oneCycle();
        checkOutput("flash2_release", 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        applyStimulus(1, 3'b000);
        checkOutput("flash2_g0", 3'b110, 3'b000, 3'b001, 3'b000, 2'd0);

        // Asynchronous reset mid-yellow clears pending requests
        $display("[TB] async reset sequence");
        green_time  = '0;
        yellow_time = 8'd4;
        ped_req     = 3'b100;
        oneCycle();
        ped_req     = 3'b000;
        applyStimulus(1, 3'b000);
        checkOutput("rst_pre_yellow", 3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        @(posedge clk);
        #1;
        yellow_time = 8'd1;
        rst_n = 1'b1;
        applyStimulus(7, 3'b000);
        checkOutput("rst_ped_cleared", 3'b011, 3'b000, 3'b100, 3'b000, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
